// File: rtl/cache_assoc.sv
// cache_assoc: set-associative line store with true-LRU replacement.
//   Combinational tag lookup for reads; writes allocate or overwrite at posedge;
//   a write miss that displaces a valid line reports it on the evict_* outputs
//   for exactly one cycle.
// Ports:
//   clock, reset                      clock / synchronous active-high reset
//   rd1_en, rd1_idx, rd1_tag          read lookup (rd1_en only qualifies LRU/stats)
//   rd1_data, rd1_valid               hit data (zero on miss), hit flag
//   wr1_en, wr1_idx, wr1_tag, wr1_data write/allocate request
//   inv_en, inv_idx, inv_tag          invalidate request
//   evict_valid/idx/tag/data          registered displaced-line report
//   hit_count, miss_count             read statistics (CACHE_STATS_EN only)
// Build option: define CACHE_STATS_EN to add the hit/miss counters.
module cache_assoc #(
    parameter int unsigned SETS   = 64,
    parameter int unsigned WAYS   = 2,
    parameter int unsigned TAG_W  = 23,
    parameter int unsigned DATA_W = 64,
    localparam int unsigned IDX_W = $clog2(SETS),
    localparam int unsigned AGE_W = $clog2(WAYS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd1_en,
    input  logic [IDX_W-1:0]  rd1_idx,
    input  logic [TAG_W-1:0]  rd1_tag,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_valid,
    input  logic              wr1_en,
    input  logic [IDX_W-1:0]  wr1_idx,
    input  logic [TAG_W-1:0]  wr1_tag,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              inv_en,
    input  logic [IDX_W-1:0]  inv_idx,
    input  logic [TAG_W-1:0]  inv_tag,
    output logic              evict_valid,
    output logic [IDX_W-1:0]  evict_idx,
    output logic [TAG_W-1:0]  evict_tag,
    output logic [DATA_W-1:0] evict_data
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam logic [AGE_W-1:0] LRU_AGE = AGE_W'(WAYS - 1);

    // Storage: tag/data unreset, valid/age reset
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [DATA_W-1:0] r_data  [SETS][WAYS];
    logic [AGE_W-1:0]  r_age   [SETS][WAYS];
    logic [WAYS-1:0]   r_valid [SETS];

    logic              r_evict_valid;
    logic [IDX_W-1:0]  r_evict_idx;
    logic [TAG_W-1:0]  r_evict_tag;
    logic [DATA_W-1:0] r_evict_data;

    // Read lookup: a hit requires exactly one matching valid way
    logic [AGE_W:0]    w_rd_cnt;
    logic [AGE_W-1:0]  w_rd_way;
    logic              w_rd_hit;

    always_comb begin
        w_rd_cnt = '0;
        w_rd_way = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (r_valid[rd1_idx][w] && (r_tag[rd1_idx][w] == rd1_tag)) begin
                w_rd_cnt = w_rd_cnt + (AGE_W+1)'(1);
                w_rd_way = AGE_W'(w);
            end
        end
        w_rd_hit = (w_rd_cnt == (AGE_W+1)'(1));
        rd1_data = w_rd_hit ? r_data[rd1_idx][w_rd_way] : '0;
    end

    assign rd1_valid = w_rd_hit;

    // Write lookup: hit way, lowest invalid way, LRU way
    logic              w_wr_hit;
    logic [AGE_W-1:0]  w_wr_hit_way;
    logic              w_any_inv;
    logic [AGE_W-1:0]  w_inv_way;
    logic [AGE_W-1:0]  w_lru_way;
    logic [AGE_W-1:0]  w_wr_way;
    logic              w_evict;

    always_comb begin
        w_wr_hit     = 1'b0;
        w_wr_hit_way = '0;
        w_any_inv    = 1'b0;
        w_inv_way    = '0;
        w_lru_way    = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!w_wr_hit && r_valid[wr1_idx][w] && (r_tag[wr1_idx][w] == wr1_tag)) begin
                w_wr_hit     = 1'b1;
                w_wr_hit_way = AGE_W'(w);
            end
            if (!w_any_inv && !r_valid[wr1_idx][w]) begin
                w_any_inv = 1'b1;
                w_inv_way = AGE_W'(w);
            end
            if (r_age[wr1_idx][w] == LRU_AGE) begin
                w_lru_way = AGE_W'(w);
            end
        end
        w_wr_way = w_wr_hit ? w_wr_hit_way : (w_any_inv ? w_inv_way : w_lru_way);
        // With no invalid way the LRU victim is necessarily valid
        w_evict  = wr1_en && !w_wr_hit && !w_any_inv;
    end

    // Read-hit LRU update yields to a write in the same set
    logic w_rd_touch;
    logic w_inv_apply;

    assign w_rd_touch  = rd1_en && w_rd_hit && !(wr1_en && (wr1_idx == rd1_idx));
    assign w_inv_apply = inv_en && !(wr1_en && (wr1_idx == inv_idx));

    // Aged copies of the two accessed sets
    logic [AGE_W-1:0] w_wr_age_nxt [WAYS];
    logic [AGE_W-1:0] w_rd_age_nxt [WAYS];

    always_comb begin
        for (int w = 0; w < int'(WAYS); w++) begin
            if (AGE_W'(w) == w_wr_way) begin
                w_wr_age_nxt[w] = '0;
            end else if (r_age[wr1_idx][w] < r_age[wr1_idx][w_wr_way]) begin
                w_wr_age_nxt[w] = r_age[wr1_idx][w] + AGE_W'(1);
            end else begin
                w_wr_age_nxt[w] = r_age[wr1_idx][w];
            end
            if (AGE_W'(w) == w_rd_way) begin
                w_rd_age_nxt[w] = '0;
            end else if (r_age[rd1_idx][w] < r_age[rd1_idx][w_rd_way]) begin
                w_rd_age_nxt[w] = r_age[rd1_idx][w] + AGE_W'(1);
            end else begin
                w_rd_age_nxt[w] = r_age[rd1_idx][w];
            end
        end
    end

    // Valid bits, ages and eviction report
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < int'(SETS); s++) begin
                r_valid[s] <= '0;
                for (int w = 0; w < int'(WAYS); w++) begin
                    r_age[s][w] <= AGE_W'(w);
                end
            end
            r_evict_valid <= 1'b0;
        end else begin
            if (w_inv_apply) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    if (r_valid[inv_idx][w] && (r_tag[inv_idx][w] == inv_tag)) begin
                        r_valid[inv_idx][w] <= 1'b0;
                    end
                end
            end
            if (w_rd_touch) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    r_age[rd1_idx][w] <= w_rd_age_nxt[w];
                end
            end
            if (wr1_en) begin
                r_valid[wr1_idx][w_wr_way] <= 1'b1;
                for (int w = 0; w < int'(WAYS); w++) begin
                    r_age[wr1_idx][w] <= w_wr_age_nxt[w];
                end
            end
            r_evict_valid <= w_evict;
        end
    end

    // Line payload and eviction snapshot; reset only gates the write
    always_ff @(posedge clock) begin
        if (!reset && wr1_en) begin
            r_tag[wr1_idx][w_wr_way]  <= wr1_tag;
            r_data[wr1_idx][w_wr_way] <= wr1_data;
        end
        if (!reset && w_evict) begin
            r_evict_idx  <= wr1_idx;
            r_evict_tag  <= r_tag[wr1_idx][w_wr_way];
            r_evict_data <= r_data[wr1_idx][w_wr_way];
        end
    end

    assign evict_valid = r_evict_valid;
    assign evict_idx   = r_evict_idx;
    assign evict_tag   = r_evict_tag;
    assign evict_data  = r_evict_data;

`ifdef CACHE_STATS_EN
    // Saturating read hit/miss counters
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (rd1_en) begin
            if (w_rd_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (!w_rd_hit && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: doc/cache_assoc.md
CACHE_ASSOC -- requirements
Module: cache_assoc

Interface
REQ-001 Parameter SETS, default 64, number of sets (power of two, >=2); IDX_W = log2(SETS).
REQ-002 Parameter WAYS, default 2, associativity (power of two, 2..8); AGE_W = log2(WAYS).
REQ-003 Parameter TAG_W, default 23, tag width.
REQ-004 Parameter DATA_W, default 64, line data width.
REQ-005 clock  in  1  single clock; all state updates on posedge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rd1_en  in  1  read lookup qualifier (LRU/stat update only).
REQ-008 rd1_idx  in  IDX_W  read set index.
REQ-009 rd1_tag  in  TAG_W  read tag.
REQ-010 rd1_data  out  DATA_W  data of hitting way; all zeros on miss.
REQ-011 rd1_valid  out  1  read hit.
REQ-012 wr1_en  in  1  write/allocate request.
REQ-013 wr1_idx  in  IDX_W  write set index.
REQ-014 wr1_tag  in  TAG_W  write tag.
REQ-015 wr1_data  in  DATA_W  write data.
REQ-016 inv_en  in  1  invalidate request.
REQ-017 inv_idx, inv_tag  in  IDX_W, TAG_W  line to invalidate.
REQ-018 evict_valid  out  1  registered pulse: valid line displaced by last-cycle write.
REQ-019 evict_idx, evict_tag, evict_data  out  IDX_W, TAG_W, DATA_W  displaced line contents.

Function
REQ-020 Read path SHALL be combinational: rd1_valid = 1 iff exactly one valid way in set rd1_idx has tag == rd1_tag; no write-to-read bypass (same-cycle write not visible until next cycle).
REQ-021 Write hit (valid way in wr1_idx with tag wr1_tag) SHALL overwrite that way's data at posedge; no eviction.
REQ-022 Write miss SHALL allocate lowest-index invalid way; if none, the LRU way (age == WAYS-1); tag, data written, valid set.
REQ-023 If write miss displaces a valid line, evict_valid SHALL be 1 for exactly the following cycle with the old idx/tag/data; otherwise 0.
REQ-024 LRU: per-way AGE_W-bit ages per set, always a permutation of 0..WAYS-1; on access to way w, ways with age < age(w) increment, age(w) <= 0.
REQ-025 Accesses updating LRU: any wr1_en; rd1_en with hit. Read miss SHALL not change state.
REQ-026 Read hit and write to same set same cycle: only write access updates LRU.
REQ-027 inv_en SHALL clear valid of the matching way (no match: no effect); ages unchanged; no eviction output.
REQ-028 inv_en and wr1_en to same set same cycle: invalidate SHALL be ignored; different sets: both applied.
REQ-029 Read and write index/tag fully independent otherwise; back-to-back writes every cycle SHALL be supported with no stall.

Reset
REQ-030 On reset all valid bits SHALL clear, way w age SHALL be w in every set (way WAYS-1 is LRU), evict_valid SHALL be 0.
REQ-031 Data and tag arrays SHALL not be reset; rd1_valid SHALL be 0 and rd1_data zeros the cycle after reset.
REQ-032 reset asserted with wr1_en/inv_en SHALL dominate: the request is dropped.

Configuration
REQ-033 Macro CACHE_STATS_EN defined: outputs hit_count, miss_count (32 bits each) SHALL count rd1_en hits/misses, saturate at 32'hFFFFFFFF, clear on reset.
REQ-034 Macro CACHE_STATS_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-035 Reset, read idx 5 tag 0x10 -> rd1_valid 0, rd1_data 0.
REQ-036 Write idx 3 tag 0x1 data 0xAAAA, next cycle read idx 3 tag 0x1 -> hit, data 0xAAAA; same-cycle read -> miss.
REQ-037 WAYS=2: write idx 3 tags 0x1, 0x2, read-hit 0x1, write tag 0x3 -> evict_valid 1 next cycle, evict_tag 0x2; tags 0x1, 0x3 hit.
REQ-038 Write idx 3 tag 0x1 data 0x5 then data 0x6 -> no eviction, read returns 0x6.
REQ-039 Invalidate idx 3 tag 0x1 -> miss; following write tag 0x4 fills freed way, evict_valid 0.
REQ-040 CACHE_STATS_EN: 3 rd1_en hits, 2 misses -> hit_count 3, miss_count 2; reset -> both 0.
